// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: byte-path and register-bank signals between the SPI
// slave front end / register bank (master side) and the frame decoder (slave side).
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 4
);
  logic              _CS;
  logic              ByteReady;
  logic [7:0]        RxByte;
  logic [7:0]        RegRdData;
  logic              RegWrEn;
  logic [ADDR_W-1:0] RegAddr;
  logic [7:0]        RegWrData;
  logic              TxLoad;
  logic [7:0]        TxByte;
  logic              Busy;
  logic              FrameError;

  modport master (
    output _CS, ByteReady, RxByte, RegRdData,
    input  RegWrEn, RegAddr, RegWrData, TxLoad, TxByte, Busy, FrameError
  );

  modport slave (
    input  _CS, ByteReady, RxByte, RegRdData,
    output RegWrEn, RegAddr, RegWrData, TxLoad, TxByte, Busy, FrameError
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: brings SPI bytes into the CLK domain and decodes frames
// (command byte + data bytes) into auto-incrementing register bank writes.
// Optional read-back path enabled by defining SPI_READBACK_EN.
module spi_cmd_decoder #(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             _RST,
  spi_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] br_sync;
  logic                   br_prev;
  logic                   cs_s;
  logic                   byte_ev;
  logic [7:0]             cmd_addr;
  logic                   addr_bad;
  logic [ADDR_W-1:0]      start_addr;
  logic [ADDR_W-1:0]      reg_addr;
  logic [ADDR_W-1:0]      addr_next;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   busy;
  logic                   frame_err;
`ifdef SPI_READBACK_EN
  logic                   tx_pend;
  logic                   tx_load;
  logic [7:0]             tx_byte;
`endif

  // Input synchronizers (idle values: _CS high, ByteReady low) and byte-edge history
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      cs_sync <= '1;
      br_sync <= '0;
      br_prev <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus._CS};
      br_sync <= {br_sync[SYNC_STAGES-2:0], bus.ByteReady};
      br_prev <= br_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign byte_ev    = br_sync[SYNC_STAGES-1] & ~br_prev;
  assign cmd_addr   = {1'b0, bus.RxByte[6:0]};
  assign addr_bad   = cmd_addr >= NUM_REGS_B;
  assign start_addr = ADDR_W'(cmd_addr);
  assign addr_next  = (reg_addr == LAST_ADDR) ? '0 : reg_addr + 1'b1;

  // Frame decoder FSM with registered strobes and data outputs
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state     <= IDLE;
      reg_addr  <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_READBACK_EN
      tx_pend   <= 1'b0;
      tx_load   <= 1'b0;
      tx_byte   <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      busy  <= ~cs_s;
`ifdef SPI_READBACK_EN
      tx_load <= 1'b0;
`endif
      // address post-increments in the cycle after each write strobe
      if (wr_en)
        reg_addr <= addr_next;
      if (cs_s) begin
        // deselect wins over a coincident byte event; the byte is dropped
        state <= IDLE;
`ifdef SPI_READBACK_EN
        tx_pend <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state     <= CMD;
            frame_err <= 1'b0;
          end
          CMD: begin
            if (byte_ev) begin
              if (addr_bad) begin
                state     <= DISCARD;
                frame_err <= 1'b1;
              end else if (!bus.RxByte[7]) begin
                state    <= WRITE;
                reg_addr <= start_addr;
              end else begin
`ifdef SPI_READBACK_EN
                state    <= READ;
                reg_addr <= start_addr;
                tx_pend  <= 1'b1;
`else
                state     <= DISCARD;
                frame_err <= 1'b1;
`endif
              end
            end
          end
          WRITE: begin
            if (byte_ev) begin
              wr_en   <= 1'b1;
              wr_data <= bus.RxByte;
            end
          end
`ifdef SPI_READBACK_EN
          READ: begin
            // RegRdData follows RegAddr, so the load happens one cycle after the address settles
            if (tx_pend) begin
              tx_load <= 1'b1;
              tx_byte <= bus.RegRdData;
              tx_pend <= 1'b0;
            end
            if (byte_ev) begin
              reg_addr <= addr_next;
              tx_pend  <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.RegWrEn    = wr_en;
  assign bus.RegAddr    = reg_addr;
  assign bus.RegWrData  = wr_data;
  assign bus.Busy       = busy;
  assign bus.FrameError = frame_err;

`ifdef SPI_READBACK_EN
  assign bus.TxLoad = tx_load;
  assign bus.TxByte = tx_byte;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^bus.RegRdData;
  assign bus.TxLoad     = 1'b0;
  assign bus.TxByte     = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: table vectors, randomized frames against a frame-level
// reference model, and hand sequences for latency, deselect and reset corners.
module tb_spi_cmd_decoder;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int SS = 2;

  logic CLK = 1'b0;
  logic _RST;
  always #5 CLK = ~CLK;

  spi_cmd_decoder_if #(.ADDR_W(AW)) bus ();

  spi_cmd_decoder #(.NUM_REGS(NR), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .CLK (CLK),
    ._RST(_RST),
    .bus (bus.slave)
  );

  // Environment register bank driven by the decoder's write port
  logic [7:0] env_bank [NR] = '{default: 8'h00};
  assign bus.RegRdData = env_bank[bus.RegAddr];

  logic [11:0] wq [$];
  logic [7:0]  tq [$];
  int          both_hi = 0;

  always @(negedge CLK) begin
    if (bus.RegWrEn) begin
      wq.push_back({bus.RegAddr, bus.RegWrData});
      env_bank[bus.RegAddr] <= bus.RegWrData;
    end
    if (bus.TxLoad) tq.push_back(bus.TxByte);
    if (bus.RegWrEn && bus.TxLoad) both_hi++;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic busy_mid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.RxByte    = b;
    bus.ByteReady = 1'b1;
    cycles(5);
    bus.ByteReady = 1'b0;
    cycles(5);
  endtask

  task automatic frame(input int n, input logic [63:0] bytes);
    @(negedge CLK);
    bus._CS = 1'b0;
    cycles(5);
    busy_mid = bus.Busy;
    for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
    cycles(4);
    bus._CS = 1'b1;
    cycles(6);
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [31:0]      b;
    logic [1:0]       nw;
    logic [2:0][11:0] w;
    logic             fe;
  } vec_t;

  vec_t        vt [7];
  logic [7:0]  model_bank [NR];
  logic [3:0]  ref_addr;
  logic [11:0] ew [$];
  logic [7:0]  et [$];
  logic        efe;
  logic [7:0]  cmd;
  logic [7:0]  d;
  logic [63:0] bytes;
  int          r, nd, a, ntot, first, width;

  initial begin
    vt[0] = '{n: 3'd3, b: 32'h00BBAA03, nw: 2'd2, w: {12'h000, 12'h4BB, 12'h3AA}, fe: 1'b0};
    vt[1] = '{n: 3'd4, b: 32'h3322110F, nw: 2'd3, w: {12'h133, 12'h022, 12'hF11}, fe: 1'b0};
    vt[2] = '{n: 3'd2, b: 32'h00005520, nw: 2'd0, w: '0, fe: 1'b1};
    vt[3] = '{n: 3'd2, b: 32'h00000100, nw: 2'd1, w: {12'h000, 12'h000, 12'h001}, fe: 1'b0};
    vt[4] = '{n: 3'd2, b: 32'h0000127F, nw: 2'd0, w: '0, fe: 1'b1};
    vt[5] = '{n: 3'd2, b: 32'h00001210, nw: 2'd0, w: '0, fe: 1'b1};
    vt[6] = '{n: 3'd2, b: 32'h0000440E, nw: 2'd1, w: {12'h000, 12'h000, 12'hE44}, fe: 1'b0};
    for (int i = 0; i < NR; i++) model_bank[i] = 8'h00;
    ref_addr = 4'h0;

    _RST = 1'b0;
    bus._CS = 1'b1;
    bus.ByteReady = 1'b0;
    bus.RxByte = 8'h00;
    cycles(3);
    chk("rst_wren", 32'(bus.RegWrEn), 32'd0);
    chk("rst_addr", 32'(bus.RegAddr), 32'd0);
    chk("rst_wdata", 32'(bus.RegWrData), 32'd0);
    chk("rst_tx", {23'd0, bus.TxLoad, bus.TxByte}, 32'd0);
    chk("rst_busy_fe", {30'd0, bus.Busy, bus.FrameError}, 32'd0);
    @(negedge CLK) _RST = 1'b1;
    cycles(4);

    // Randomized frames against the frame-level model
    for (int f = 0; f < 30; f++) begin
      r  = int'($urandom_range(0, 11));
      nd = int'($urandom_range(0, 4));
      if (r <= 6)       cmd = {1'b0, 7'($urandom_range(0, 15))};
      else if (r == 7)  cmd = {1'b0, 7'($urandom_range(16, 127))};
      else if (r <= 9)  cmd = {1'b1, 7'($urandom_range(0, 15))};
      else              cmd = {1'b1, 7'($urandom_range(16, 127))};
      ntot = (r == 11) ? 0 : nd + 1;
      bytes = {$urandom, $urandom};
      bytes[7:0] = cmd;
      ew.delete();
      et.delete();
      if (ntot == 0) begin
        efe = 1'b0;
      end else begin
        a = int'(cmd[6:0]);
        if (a >= NR) begin
          efe = 1'b1;
        end else if (!cmd[7]) begin
          efe = 1'b0;
          for (int j = 0; j < nd; j++) begin
            d = bytes[8*(j+1) +: 8];
            ew.push_back({4'((a + j) % NR), d});
            model_bank[(a + j) % NR] = d;
          end
          ref_addr = 4'((a + nd) % NR);
        end else begin
`ifdef SPI_READBACK_EN
          efe = 1'b0;
          for (int j = 0; j <= nd; j++) et.push_back(model_bank[(a + j) % NR]);
          ref_addr = 4'((a + nd) % NR);
`else
          efe = 1'b1;
`endif
        end
      end
      wq.delete();
      tq.delete();
      frame(ntot, bytes);
      chk("rnd_nwr", 32'(wq.size()), 32'(ew.size()));
      for (int k = 0; k < ew.size() && k < wq.size(); k++) chk("rnd_wr", 32'(wq[k]), 32'(ew[k]));
      chk("rnd_ntx", 32'(tq.size()), 32'(et.size()));
      for (int k = 0; k < et.size() && k < tq.size(); k++) chk("rnd_tx", 32'(tq[k]), 32'(et[k]));
      chk("rnd_fe", 32'(bus.FrameError), 32'(efe));
      chk("rnd_addr", 32'(bus.RegAddr), 32'(ref_addr));
      chk("rnd_busy", 32'(bus.Busy), 32'd0);
    end

    // Table vectors
    for (int unsigned i = 0; i < 7; i++) begin
      wq.delete();
      frame(int'(vt[i].n), {32'h0, vt[i].b});
      chk("tbl_nwr", 32'(wq.size()), 32'(vt[i].nw));
      for (int unsigned k = 0; k < 32'(vt[i].nw) && k < 32'(wq.size()); k++)
        chk("tbl_wr", 32'(wq[k]), 32'(vt[i].w[k]));
      chk("tbl_fe", 32'(bus.FrameError), 32'(vt[i].fe));
      chk("tbl_busy_mid", 32'(busy_mid), 32'd1);
      chk("tbl_busy_end", 32'(bus.Busy), 32'd0);
    end

    // Latency from ByteReady pin rise to write strobe, and strobe width
    wq.delete();
    @(negedge CLK) bus._CS = 1'b0;
    cycles(5);
    send_byte(8'h09);
    @(negedge CLK);
    bus.RxByte = 8'h5A;
    bus.ByteReady = 1'b1;
    first = -1;
    width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      if (bus.RegWrEn) begin
        width++;
        if (first < 0) first = k;
      end
    end
    bus.ByteReady = 1'b0;
    cycles(5);
    bus._CS = 1'b1;
    cycles(6);
    chk("lat_edges", 32'(first), 32'(SS + 1));
    chk("lat_width", 32'(width), 32'd1);
    chk("lat_wr", 32'(wq.size() == 1 ? wq[0] : 12'hFFF), 32'h95A);

    // Deselect and byte event arriving together: byte dropped
    wq.delete();
    @(negedge CLK) bus._CS = 1'b0;
    cycles(5);
    send_byte(8'h03);
    @(negedge CLK);
    bus.RxByte = 8'hEE;
    bus.ByteReady = 1'b1;
    bus._CS = 1'b1;
    cycles(8);
    bus.ByteReady = 1'b0;
    cycles(6);
    chk("cs_win_nwr", 32'(wq.size()), 32'd0);
    chk("cs_win_addr", 32'(bus.RegAddr), 32'd3);

    // Deselect mid-byte, then a normal frame
    wq.delete();
    @(negedge CLK) bus._CS = 1'b0;
    cycles(5);
    send_byte(8'h05);
    @(negedge CLK) bus.RxByte = 8'h0A;
    cycles(3);
    bus._CS = 1'b1;
    cycles(6);
    chk("abort_nwr", 32'(wq.size()), 32'd0);
    frame(2, 64'h6601);
    chk("after_abort_wr", 32'(wq.size() == 1 ? wq[0] : 12'hFFF), 32'h166);

    // Read command against bank[6]=0x9C
    frame(2, 64'h9C06);
    wq.delete();
    tq.delete();
    frame(2, 64'h0086);
`ifdef SPI_READBACK_EN
    chk("rd_ntx", 32'(tq.size()), 32'd2);
    chk("rd_tx0", 32'(tq.size() > 0 ? tq[0] : 8'h00), 32'h9C);
    chk("rd_addr", 32'(bus.RegAddr), 32'd7);
    chk("rd_fe", 32'(bus.FrameError), 32'd0);
`else
    chk("rd_fe", 32'(bus.FrameError), 32'd1);
    chk("rd_ntx", 32'(tq.size()), 32'd0);
`endif
    chk("rd_nwr", 32'(wq.size()), 32'd0);

    // Reset mid-frame
    wq.delete();
    @(negedge CLK) bus._CS = 1'b0;
    cycles(5);
    send_byte(8'h02);
    send_byte(8'h77);
    chk("mid_wr", 32'(wq.size() == 1 ? wq[0] : 12'hFFF), 32'h277);
    @(negedge CLK);
    #2 _RST = 1'b0;
    #1;
    chk("arst_wdata_addr", {20'd0, bus.RegAddr, bus.RegWrData}, 32'd0);
    chk("arst_flags", {28'd0, bus.RegWrEn, bus.TxLoad, bus.Busy, bus.FrameError}, 32'd0);
    wq.delete();
    send_byte(8'h88);
    chk("in_rst_nwr", 32'(wq.size()), 32'd0);
    @(negedge CLK) _RST = 1'b1;
    cycles(6);
    send_byte(8'h01);
    send_byte(8'h42);
    cycles(4);
    bus._CS = 1'b1;
    cycles(6);
    chk("rst_cs_low_wr", 32'(wq.size() == 1 ? wq[0] : 12'hFFF), 32'h142);

    chk("wr_tx_overlap", 32'(both_hi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
